// File: rtl/svm_pkg.sv
// Shared types and width helpers for the sequential SVM datapath.
package svm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    DECIDE = 2'd2
  } state_e;

  // Wide enough for N_features full-scale products plus the bias, with a spare sign bit.
  function automatic int acc_width(input int fw, input int ww, input int bw, input int nf);
    int m;
    m = fw + 1 + ww + $clog2(nf);
    if (bw > m) m = bw;
    return m + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/svm_mac_acc.sv
// Signed multiply-accumulate: acc += signed({0,feat}) * wgt, with clear taking priority.
module svm_mac_acc
  import svm_pkg::*;
#(
  parameter int FW = 4,
  parameter int WW = 8,
  parameter int AW = acc_width(FW, WW, 12, 11)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [FW-1:0]        feat_i,
  input  logic signed [WW-1:0] wgt_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [FW:0]      feat_s;
  logic signed [FW+WW:0]   prod;
  logic signed [AW-1:0]    acc_q, acc_d;

  assign feat_s = $signed({1'b0, feat_i});
  assign prod   = feat_s * wgt_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + AW'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/svm_seq_datapath.sv
// Sequential one-vs-one SVM datapath: one feature MAC per cycle, then a binary decision
// handed to the external picker, repeated until the picker reports a winner.
module svm_seq_datapath
  import svm_pkg::*;
#(
  parameter int N_features  = 11,
  parameter int featWidth   = 4,
  parameter int weightWidth = 8,
  parameter int biasWidth   = 12,
  parameter int N_classes   = 7
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [featWidth*N_features-1:0]      features,
  input  logic signed [weightWidth*N_features-1:0] weight,
  input  logic signed [biasWidth-1:0]          bia,
  input  logic                                 ready,
  output logic                                 svmready,
  output logic                                 w_class,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int AccWidth = acc_width(featWidth, weightWidth, biasWidth, N_features);
  localparam int IdxW     = idx_width(N_features);
  localparam int CmpW     = idx_width(N_classes);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_features - 1);
  localparam logic [CmpW-1:0] CmpLast = CmpW'(N_classes - 1);

  state_e                          state_q, state_d;
  logic [featWidth*N_features-1:0] features_q, features_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [CmpW-1:0]                 cmp_q, cmp_d, cmp_inc;
  logic                            err_q, err_d;

  logic                            mac_clr, mac_en;
  logic [featWidth-1:0]            feat_cur;
  logic signed [weightWidth-1:0]   wgt_cur;
  logic signed [AccWidth-1:0]      acc, sum;

  assign feat_cur = features_q[idx_q*featWidth +: featWidth];
  assign wgt_cur  = weight[idx_q*weightWidth +: weightWidth];
  assign sum      = acc + AccWidth'(bia);
  assign cmp_inc  = cmp_q + 1'b1;

  svm_mac_acc #(
    .FW (featWidth),
    .WW (weightWidth),
    .AW (AccWidth)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .feat_i (feat_cur),
    .wgt_i  (wgt_cur),
    .acc_o  (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      features_q <= '0;
      idx_q      <= '0;
      cmp_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      features_q <= features_d;
      idx_q      <= idx_d;
      cmp_q      <= cmp_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    features_d = features_q;
    idx_d      = idx_q;
    cmp_d      = cmp_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          features_d = features;
          idx_d      = '0;
          cmp_d      = '0;
          err_d      = 1'b0;
          state_d    = MAC;
        end
      end
      MAC: begin
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = DECIDE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DECIDE: begin
        idx_d = '0;
        if (ready) begin
          state_d = IDLE;
        end else begin
          cmp_d = cmp_inc;
          // Every classifier has been evaluated without the picker settling on a winner.
          if (cmp_inc == CmpLast) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mac_clr  = ((state_q == IDLE) && start) || ((state_q == DECIDE) && !ready);
    mac_en   = (state_q == MAC);
    svmready = (state_q == DECIDE);
    busy     = (state_q != IDLE);
    done     = (state_q == DECIDE) && ready;
    w_class  = (state_q == DECIDE) && (sum[AccWidth-1] || (sum == '0));
    err      = err_q;
  end

endmodule

// File: tb/tb_svm_seq_datapath.sv
// Directed bench for svm_seq_datapath: timing, sign handling, picker chain, overflow, reset, busy start.
module tb_svm_seq_datapath;

  localparam int NF = 11;
  localparam int FW = 4;
  localparam int WW = 8;
  localparam int BW = 12;
  localparam int NC = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              ready = 1'b0;
  logic [FW*NF-1:0]  features = '0;
  logic [WW*NF-1:0]  weight = '0;
  logic [BW-1:0]     bia = '0;
  logic              svmready, w_class, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  svm_seq_datapath #(
    .N_features (NF),
    .featWidth  (FW),
    .weightWidth(WW),
    .biasWidth  (BW),
    .N_classes  (NC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .features (features),
    .weight   (weight),
    .bia      (bia),
    .ready    (ready),
    .svmready (svmready),
    .w_class  (w_class),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_feat_all(input int v);
    for (int i = 0; i < NF; i++) features[i*FW +: FW] = FW'(v);
  endtask

  task automatic set_wgt_all(input int v);
    for (int i = 0; i < NF; i++) weight[i*WW +: WW] = WW'(v);
  endtask

  function automatic int chain_feat(input int i);
    return (i * 7 + 3) % 16;
  endfunction

  function automatic int wfun(input int a, input int b, input int i);
    return ((a * 37 + b * 59 + i * 23) % 256) - 128;
  endfunction

  function automatic int bfun(input int a, input int b);
    return (((a * 13 + b * 29) % 200) - 100) * 10;
  endfunction

  task automatic drive_pair(input int a, input int b);
    for (int i = 0; i < NF; i++) weight[i*WW +: WW] = WW'(wfun(a, b, i));
    bia = BW'(bfun(a, b));
  endtask

  // Called at a negedge; start is seen by the next rising edge only.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_svm(input int n0, output int n);
    n = n0;
    do begin
      @(negedge clk);
      n++;
    end while (!svmready && n < 40);
    if (!svmready) check("svmready_timeout", 32'(svmready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, total, pwin, pnxt, gwin, s;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_svmready", 32'(svmready), 0);
    check("rst_w_class", 32'(w_class), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single MAC: sum = 11 - 11 = 0 -> w_class 1
    set_feat_all(1); set_wgt_all(1); bia = BW'(-11); ready = 1'b1;
    do_start();
    wait_svm(0, n);
    check("t1_latency", n, 12);
    check("t1_w_class", 32'(w_class), 1);
    check("t1_done", 32'(done), 1);
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_wclass_idle", 32'(w_class), 0);

    // Sign: 15 * -128 * 11 = -21120
    set_feat_all(15); set_wgt_all(-128); bia = '0;
    do_start();
    wait_svm(0, n);
    check("t2_neg_latency", n, 12);
    check("t2_neg_w_class", 32'(w_class), 1);
    @(negedge clk);
    // 15 * 127 * 11 = 20955
    set_wgt_all(127);
    do_start();
    wait_svm(0, n);
    check("t2_pos_w_class", 32'(w_class), 0);
    @(negedge clk);

    // Bias alone: sum = +1 -> 0, sum = -1 -> 1
    set_feat_all(0); bia = BW'(1);
    do_start();
    wait_svm(0, n);
    check("t2_bias_p1", 32'(w_class), 0);
    @(negedge clk);
    bia = BW'(-1);
    do_start();
    wait_svm(0, n);
    check("t2_bias_m1", 32'(w_class), 1);
    @(negedge clk);

    // Start while busy: original sum = 15*(4*-128 + 7*127) = 5655 -> 0
    set_feat_all(15); bia = '0;
    for (int i = 0; i < NF; i++) weight[i*WW +: WW] = (i < 4) ? WW'(-128) : WW'(127);
    do_start();
    repeat (3) @(negedge clk);
    check("t3_busy_mid", 32'(busy), 1);
    check("t3_svm_mid", 32'(svmready), 0);
    set_feat_all(0);
    do_start();
    wait_svm(3, n);
    check("t3_latency", n, 12);
    check("t3_w_class", 32'(w_class), 0);
    check("t3_done", 32'(done), 1);
    @(negedge clk);

    // Full chain against a golden elimination picker
    for (int i = 0; i < NF; i++) features[i*FW +: FW] = FW'(chain_feat(i));
    gwin = 0;
    for (int k = 0; k < NC - 1; k++) begin
      s = bfun(gwin, k + 1);
      for (int i = 0; i < NF; i++) s += chain_feat(i) * wfun(gwin, k + 1, i);
      exp_q.push_back((s <= 0) ? 1'b1 : 1'b0);
      if (s > 0) gwin = k + 1;
    end
    pwin = 0; pnxt = 1; total = 0; ready = 1'b0;
    drive_pair(pwin, pnxt);
    do_start();
    for (int k = 0; k < NC - 1; k++) begin
      if (k == NC - 2) ready = 1'b1;
      wait_svm(0, n);
      total += n;
      check("t4_spacing", n, 12);
      check("t4_w_class", 32'(w_class), 32'(exp_q.pop_front()));
      check("t4_done", 32'(done), (k == NC - 2) ? 1 : 0);
      if (!w_class) pwin = pnxt;
      pnxt++;
      @(posedge clk);
      #1;
      if (k < NC - 2) drive_pair(pwin, pnxt);
    end
    check("t4_total_cycles", total, 72);
    check("t4_winner", pwin, gwin);
    @(negedge clk);
    check("t4_busy_after", 32'(busy), 0);
    ready = 1'b0;

    // Overflow: picker never reports a winner
    do_start();
    for (int k = 0; k < NC - 1; k++) begin
      wait_svm(0, n);
      check("t5_no_done", 32'(done), 0);
    end
    @(negedge clk);
    check("t5_err", 32'(err), 1);
    check("t5_busy_drop", 32'(busy), 0);
    repeat (3) @(negedge clk);
    check("t5_no_more_svm", 32'(svmready), 0);
    check("t5_err_sticky", 32'(err), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset mid-MAC at idx 5, then a clean decision
    set_feat_all(1); set_wgt_all(1); bia = BW'(-11); ready = 1'b1;
    do_start();
    repeat (6) @(negedge clk);
    check("t6_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_svm", 32'(svmready), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_wclass", 32'(w_class), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    wait_svm(0, n);
    check("t6_latency", n, 12);
    check("t6_w_class", 32'(w_class), 1);
    check("t6_done", 32'(done), 1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
